// File: rtl/capbuf_pkg.sv
// Shared constants and address classification for the multi-channel capture buffer.
package capbuf_pkg;

  localparam logic [3:0] ADDR_POP_BASE = 4'd0;
  localparam logic [3:0] ADDR_CNT_BASE = 4'd8;
  localparam logic [3:0] ADDR_IRQMASK  = 4'd13;
  localparam logic [3:0] ADDR_FLUSH    = 4'd14;
  localparam logic [3:0] ADDR_OVF      = 4'd15;

  localparam logic [31:0] EMPTY_VAL_DEF = 32'h0000_00FF;

  typedef enum logic [1:0] {POP, CNT, CTRL, UNMAPPED} addr_class_e;

  // Control registers take priority so that NCH=8 count slots never shadow them.
  function automatic addr_class_e addr_class(input logic [3:0] a, input int nch);
    if (a >= ADDR_IRQMASK)
      return CTRL;
    else if (int'(a) >= int'(ADDR_POP_BASE) && int'(a) < int'(ADDR_POP_BASE) + nch)
      return POP;
    else if (int'(a) >= int'(ADDR_CNT_BASE) && int'(a) < int'(ADDR_CNT_BASE) + nch)
      return CNT;
    else
      return UNMAPPED;
  endfunction

endpackage

// File: rtl/capbuf_fifo.sv
// Single-channel circular FIFO with a show-ahead head register (dout is always the oldest word).
module capbuf_fifo
  import capbuf_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4096,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] rptr_nxt;
  logic [DW-1:0] head_p1;
  logic          push_acc;
  logic          pop_acc;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_acc  = pop && !empty;
  // A pop on a full FIFO frees the slot the push needs.
  assign push_acc = push && !flush && (!full || pop_acc);
  assign rptr_nxt = flush ? wptr : rptr + AW'(pop_acc);
  assign dout     = head_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      rptr <= rptr_nxt;
      if (push_acc)
        wptr <= wptr + AW'(1);
      if (flush)
        count <= '0;
      else
        count <= count + CW'(push_acc) - CW'(pop_acc);
    end
  end

  // Stage p1: synchronous memory read of the next head, bypassing a same-cycle write to it
  always_ff @(posedge clk) begin
    if (push_acc)
      mem[wptr] <= din;
    head_p1 <= (push_acc && (wptr == rptr_nxt)) ? din : mem[rptr_nxt];
  end

endmodule

// File: rtl/capture_buffer_mc.sv
// Multi-channel capture buffer with Avalon-MM register access.
// Optional overflow interrupt (port irq, mask register at address 13) enabled by CAPBUF_IRQ_EN.
module capture_buffer_mc
  import capbuf_pkg::*;
#(
  parameter int          NCH       = 4,
  parameter int          DW        = 32,
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] EMPTY_VAL = EMPTY_VAL_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    wr_en,
  input  logic [NCH*DW-1:0] wr_data,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [3:0]        address,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata
`ifdef CAPBUF_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  logic              rd_hit;
  logic              wr_hit;
  addr_class_e       cls;
  logic [NCH-1:0]    pop_v;
  logic [NCH-1:0]    flush_v;
  logic [NCH-1:0]    full_v;
  logic [NCH-1:0]    empty_v;
  logic [NCH-1:0]    ovf;
  logic [NCH-1:0]    ovf_set;
  logic [DW-1:0]     dout_a [NCH];
  logic [CW-1:0]     cnt_a  [NCH];
  logic [31:0]       rd_nxt_p0;
  logic              unused_wdata;

  assign rd_hit       = chipselect && read;
  assign wr_hit       = chipselect && write;
  assign cls          = addr_class(address, NCH);
  assign unused_wdata = ^writedata;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign pop_v[c]   = rd_hit && (cls == POP) && (address == 4'(c));
    assign flush_v[c] = wr_hit && (address == ADDR_FLUSH) && writedata[c];
    // A same-cycle pop makes room and a flush discards the word, so neither overflows.
    assign ovf_set[c] = wr_en[c] && full_v[c] && !pop_v[c] && !flush_v[c];

    capbuf_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_en[c]),
      .pop   (pop_v[c]),
      .flush (flush_v[c]),
      .din   (wr_data[c*DW +: DW]),
      .dout  (dout_a[c]),
      .count (cnt_a[c]),
      .full  (full_v[c]),
      .empty (empty_v[c])
    );
  end

`ifdef CAPBUF_IRQ_EN
  logic [NCH-1:0] mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr_hit && (address == ADDR_IRQMASK))
        mask <= writedata[NCH-1:0];
      irq <= |(ovf & mask);
    end
  end
`endif

  always_comb begin
    rd_nxt_p0 = EMPTY_VAL;
    case (cls)
      POP: begin
        for (int c = 0; c < NCH; c++)
          if (int'(address) == int'(ADDR_POP_BASE) + c)
            rd_nxt_p0 = empty_v[c] ? EMPTY_VAL : 32'(dout_a[c]);
      end
      CNT: begin
        for (int c = 0; c < NCH; c++)
          if (int'(address) == int'(ADDR_CNT_BASE) + c)
            rd_nxt_p0 = 32'(cnt_a[c]);
      end
      CTRL: begin
        if (address == ADDR_OVF)
          rd_nxt_p0 = 32'(ovf);
`ifdef CAPBUF_IRQ_EN
        else if (address == ADDR_IRQMASK)
          rd_nxt_p0 = 32'(mask);
`endif
      end
      default: rd_nxt_p0 = EMPTY_VAL;
    endcase
  end

  // Stage p1: registered read data and sticky overflow flags (a new overflow beats W1C)
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
      ovf      <= '0;
    end else begin
      if (rd_hit)
        readdata <= rd_nxt_p0;
      if (wr_hit && (address == ADDR_OVF))
        ovf <= (ovf & ~writedata[NCH-1:0]) | ovf_set;
      else
        ovf <= ovf | ovf_set;
    end
  end

endmodule

// File: tb/tb_capture_buffer_mc.sv
// Directed bench for capture_buffer_mc (4 channels, 8-word FIFOs) with hand-computed expectations.
module tb_capture_buffer_mc;

  localparam int NCH   = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NCH-1:0]    wr_en = '0;
  logic [NCH*DW-1:0] wr_data = '0;
  logic              chipselect = 1'b0;
  logic              read = 1'b0;
  logic              write = 1'b0;
  logic [3:0]        address = '0;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
`ifdef CAPBUF_IRQ_EN
  logic              irq;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] d;
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  capture_buffer_mc #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata)
`ifdef CAPBUF_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    chipselect = 1'b1; read = 1'b1; address = a;
    step();
    v = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] v);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = v;
    step();
    chipselect = 1'b0; write = 1'b0; writedata = '0;
  endtask

  task automatic push(input int ch, input logic [31:0] v);
    wr_en = '0;
    wr_en[ch] = 1'b1;
    wr_data[ch*DW +: DW] = v;
    step();
    wr_en = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (readdata !== 32'h0) begin
      errors++; $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0);
    end
    for (int i = 0; i < NCH; i++) begin
      rd(4'(8 + i), d);
      checks++;
      if (d !== 32'h0) begin
        errors++; $display("FAIL reset_count%0d: got %h expected %h", i, d, 32'h0);
      end
    end
    rd(4'd15, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL reset_ovf: got %h expected %h", d, 32'h0);
    end
    rd(4'd5, d);
    checks++;
    if (d !== 32'hFF) begin
      errors++; $display("FAIL unmapped_5: got %h expected %h", d, 32'hFF);
    end
    rd(4'd14, d);
    checks++;
    if (d !== 32'hFF) begin
      errors++; $display("FAIL read_flush_addr: got %h expected %h", d, 32'hFF);
    end
`ifdef CAPBUF_IRQ_EN
    exp_v = 32'h0;
`else
    exp_v = 32'hFF;
`endif
    rd(4'd13, d);
    checks++;
    if (d !== exp_v) begin
      errors++; $display("FAIL read_addr13: got %h expected %h", d, exp_v);
    end
  endtask

  task automatic test_fifo_order();
    for (int i = 0; i < 5; i++) push(1, 32'hA0 + 32'(i));
    rd(4'd9, d);
    checks++;
    if (d !== 32'd5) begin
      errors++; $display("FAIL order_count: got %h expected %h", d, 32'd5);
    end
    for (int i = 0; i < 5; i++) begin
      rd(4'd1, d);
      checks++;
      if (d !== 32'hA0 + 32'(i)) begin
        errors++; $display("FAIL order_pop%0d: got %h expected %h", i, d, 32'hA0 + 32'(i));
      end
    end
    rd(4'd1, d);
    checks++;
    if (d !== 32'hFF) begin
      errors++; $display("FAIL order_empty_pop: got %h expected %h", d, 32'hFF);
    end
    rd(4'd9, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL order_count_end: got %h expected %h", d, 32'd0);
    end
  endtask

  task automatic test_empty_push_pop();
    wr_en[1] = 1'b1;
    wr_data[1*DW +: DW] = 32'h55;
    chipselect = 1'b1; read = 1'b1; address = 4'd1;
    step();
    wr_en = '0; chipselect = 1'b0; read = 1'b0;
    checks++;
    if (readdata !== 32'hFF) begin
      errors++; $display("FAIL empty_pushpop_data: got %h expected %h", readdata, 32'hFF);
    end
    rd(4'd9, d);
    checks++;
    if (d !== 32'd1) begin
      errors++; $display("FAIL empty_pushpop_count: got %h expected %h", d, 32'd1);
    end
    rd(4'd1, d);
    checks++;
    if (d !== 32'h55) begin
      errors++; $display("FAIL empty_pushpop_word: got %h expected %h", d, 32'h55);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) push(0, 32'h10 + 32'(i));
    rd(4'd8, d);
    checks++;
    if (d !== 32'd8) begin
      errors++; $display("FAIL ovf_count_full: got %h expected %h", d, 32'd8);
    end
    rd(4'd15, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL ovf_before: got %h expected %h", d, 32'h0);
    end
    push(0, 32'h18);
    rd(4'd15, d);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL ovf_set: got %h expected %h", d, 32'h1);
    end
    rd(4'd8, d);
    checks++;
    if (d !== 32'd8) begin
      errors++; $display("FAIL ovf_count_held: got %h expected %h", d, 32'd8);
    end
    // overflow and W1C in the same cycle: the new overflow must survive
    wr_en[0] = 1'b1;
    wr_data[0 +: DW] = 32'h19;
    chipselect = 1'b1; write = 1'b1; address = 4'd15; writedata = 32'h1;
    step();
    wr_en = '0; chipselect = 1'b0; write = 1'b0; writedata = '0;
    rd(4'd15, d);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL ovf_set_beats_clear: got %h expected %h", d, 32'h1);
    end
    wr(4'd15, 32'h1);
    rd(4'd15, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL ovf_w1c: got %h expected %h", d, 32'h0);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      wr_en[0] = 1'b1;
      wr_data[0 +: DW] = 32'h20 + 32'(i);
      chipselect = 1'b1; read = 1'b1; address = 4'd0;
      step();
      wr_en = '0; chipselect = 1'b0; read = 1'b0;
      checks++;
      if (readdata !== 32'h10 + 32'(i)) begin
        errors++; $display("FAIL full_pushpop_pop%0d: got %h expected %h", i, readdata, 32'h10 + 32'(i));
      end
    end
    rd(4'd8, d);
    checks++;
    if (d !== 32'd8) begin
      errors++; $display("FAIL full_pushpop_count: got %h expected %h", d, 32'd8);
    end
    rd(4'd15, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL full_pushpop_ovf: got %h expected %h", d, 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      exp_v = (i < 4) ? 32'h14 + 32'(i) : 32'h20 + 32'(i - 4);
      rd(4'd0, d);
      checks++;
      if (d !== exp_v) begin
        errors++; $display("FAIL wrap_drain%0d: got %h expected %h", i, d, exp_v);
      end
    end
    rd(4'd0, d);
    checks++;
    if (d !== 32'hFF) begin
      errors++; $display("FAIL wrap_empty_pop: got %h expected %h", d, 32'hFF);
    end
  endtask

  task automatic test_flush();
    push(2, 32'h30);
    push(2, 32'h31);
    push(2, 32'h32);
    push(3, 32'h40);
    rd(4'd10, d);
    checks++;
    if (d !== 32'd3) begin
      errors++; $display("FAIL flush_count_before: got %h expected %h", d, 32'd3);
    end
    wr_en[2] = 1'b1;
    wr_data[2*DW +: DW] = 32'h77;
    chipselect = 1'b1; write = 1'b1; address = 4'd14; writedata = 32'h4;
    step();
    wr_en = '0; chipselect = 1'b0; write = 1'b0; writedata = '0;
    rd(4'd10, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL flush_count_after: got %h expected %h", d, 32'd0);
    end
    rd(4'd2, d);
    checks++;
    if (d !== 32'hFF) begin
      errors++; $display("FAIL flush_pop: got %h expected %h", d, 32'hFF);
    end
    rd(4'd15, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL flush_ovf: got %h expected %h", d, 32'h0);
    end
    rd(4'd11, d);
    checks++;
    if (d !== 32'd1) begin
      errors++; $display("FAIL flush_other_count: got %h expected %h", d, 32'd1);
    end
    rd(4'd3, d);
    checks++;
    if (d !== 32'h40) begin
      errors++; $display("FAIL flush_other_data: got %h expected %h", d, 32'h40);
    end
    push(2, 32'h33);
    rd(4'd2, d);
    checks++;
    if (d !== 32'h33) begin
      errors++; $display("FAIL flush_then_push: got %h expected %h", d, 32'h33);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      wr_en = '1;
      for (int c = 0; c < NCH; c++) wr_data[c*DW +: DW] = 32'h50 + 32'(16 * c + i);
      step();
    end
    wr_en = '0;
    for (int i = 0; i < 6; i++) push(3, 32'h90 + 32'(i));
    rd(4'd15, d);
    checks++;
    if (d !== 32'h8) begin
      errors++; $display("FAIL mid_ovf_before: got %h expected %h", d, 32'h8);
    end
    wr_en = '1;
    reset = 1'b1;
    chipselect = 1'b1; read = 1'b1; address = 4'd0;
    step();
    reset = 1'b0; wr_en = '0; chipselect = 1'b0; read = 1'b0;
    checks++;
    if (readdata !== 32'h0) begin
      errors++; $display("FAIL mid_readdata: got %h expected %h", readdata, 32'h0);
    end
`ifdef CAPBUF_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL mid_irq: got %b expected %b", irq, 1'b0);
    end
`endif
    for (int i = 0; i < NCH; i++) begin
      rd(4'(8 + i), d);
      checks++;
      if (d !== 32'h0) begin
        errors++; $display("FAIL mid_count%0d: got %h expected %h", i, d, 32'h0);
      end
    end
    rd(4'd15, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL mid_ovf_after: got %h expected %h", d, 32'h0);
    end
    rd(4'd0, d);
    checks++;
    if (d !== 32'hFF) begin
      errors++; $display("FAIL mid_pop: got %h expected %h", d, 32'hFF);
    end
  endtask

`ifdef CAPBUF_IRQ_EN
  task automatic test_irq();
    wr(4'd13, 32'h2);
    rd(4'd13, d);
    checks++;
    if (d !== 32'h2) begin
      errors++; $display("FAIL irq_mask_read: got %h expected %h", d, 32'h2);
    end
    for (int i = 0; i < 9; i++) push(0, 32'(i));
    step();
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_masked_ch0: got %b expected %b", irq, 1'b0);
    end
    for (int i = 0; i < 9; i++) push(1, 32'(i));
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_latency: got %b expected %b", irq, 1'b0);
    end
    step();
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_ch1: got %b expected %b", irq, 1'b1);
    end
    wr(4'd15, 32'h2);
    step();
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_cleared: got %b expected %b", irq, 1'b0);
    end
    rd(4'd15, d);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL irq_ovf_left: got %h expected %h", d, 32'h1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fifo_order();
    test_empty_push_pop();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_reset_mid();
`ifdef CAPBUF_IRQ_EN
    test_irq();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
